// File: rtl/adc_rr_pkt_scheduler.sv
// Round-robin packet scheduler: FWFT ADC channel FIFOs -> AXI-Stream TX, with inter-packet gap.
// Optional header beat per packet when ADC_SCHED_HDR_EN is defined.
module adc_rr_pkt_scheduler #(
    parameter int NUM_CH     = 6,
    parameter int PKT_LEN    = 1024,
    parameter int GAP_CYCLES = 8192,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] almost_empty,
    input  logic              m_axis_tready,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic [NUM_CH-1:0] rd_en,
    output logic [2:0]        sel,
    output logic              pkt_hdr,
    output logic [15:0]       hdr_data
);

    // state | meaning
    // IDLE  | waiting for full with at least one non-empty FIFO
    // ARB   | one cycle: pick next non-empty channel after last_grant
    // SEND  | stream beats from the granted FIFO until tlast is accepted
    // GAP   | enforce GAP_CYCLES idle cycles before the next arbitration
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q;
    logic [2:0]       sel_q;
    logic [2:0]       last_grant_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] gap_cnt_q;

    logic [7:0]       empty_x;
    logic [7:0]       aempty_x;
    logic [2:0]       grant_d;
    logic             any_ne;
    logic             data_valid;
    logic             accept;
    logic             tlast;

    // Pad to 8 entries so a 3-bit select never indexes past the vector.
    always_comb begin
        empty_x  = '1;
        aempty_x = '0;
        empty_x[NUM_CH-1:0]  = empty;
        aempty_x[NUM_CH-1:0] = almost_empty;
    end

    assign any_ne = ~&empty;

    // Walk offsets from farthest to nearest so the nearest non-empty channel wins.
    always_comb begin
        grant_d = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (!empty_x[3'((int'(last_grant_q) + i) % NUM_CH)]) begin
                grant_d = 3'((int'(last_grant_q) + i) % NUM_CH);
            end
        end
    end

`ifdef ADC_SCHED_HDR_EN
    logic        hdr_pend_q;
    logic [12:0] pkt_seq_q;
    logic        hdr_beat;

    assign hdr_beat   = (state_q == S_SEND) && hdr_pend_q;
    assign data_valid = (state_q == S_SEND) && !hdr_pend_q && !empty_x[sel_q];
    assign m_axis_tvalid = hdr_beat | data_valid;
    assign pkt_hdr    = hdr_beat;
    assign hdr_data   = hdr_beat ? {pkt_seq_q, sel_q} : 16'h0000;
`else
    assign data_valid = (state_q == S_SEND) && !empty_x[sel_q];
    assign m_axis_tvalid = data_valid;
    assign pkt_hdr    = 1'b0;
    assign hdr_data   = 16'h0000;
`endif

    assign accept       = data_valid && m_axis_tready;
    assign tlast        = data_valid && ((beat_cnt_q == BEAT_LAST) || aempty_x[sel_q]);
    assign m_axis_tlast = tlast;
    assign rd_en        = accept ? (NUM_CH'(1) << sel_q) : '0;
    assign sel          = sel_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            last_grant_q <= 3'(NUM_CH - 1);
            beat_cnt_q   <= '0;
            gap_cnt_q    <= '0;
`ifdef ADC_SCHED_HDR_EN
            hdr_pend_q   <= 1'b0;
            pkt_seq_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (full && any_ne) state_q <= S_ARB;
                end
                S_ARB: begin
                    if (any_ne) begin
                        sel_q        <= grant_d;
                        last_grant_q <= grant_d;
                        beat_cnt_q   <= '0;
`ifdef ADC_SCHED_HDR_EN
                        hdr_pend_q   <= 1'b1;
`endif
                        state_q      <= S_SEND;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SEND: begin
`ifdef ADC_SCHED_HDR_EN
                    if (hdr_pend_q && m_axis_tready) hdr_pend_q <= 1'b0;
`endif
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (tlast) begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
`ifdef ADC_SCHED_HDR_EN
                            pkt_seq_q <= pkt_seq_q + 13'd1;
`endif
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                    if (gap_cnt_q == GAP_LAST) state_q <= any_ne ? S_ARB : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_rr_pkt_scheduler.sv
// Directed bench for adc_rr_pkt_scheduler with small packet/gap parameters and modelled FWFT FIFOs.
module tb_adc_rr_pkt_scheduler;

    localparam int NUM_CH     = 6;
    localparam int PKT_LEN    = 8;
    localparam int GAP_CYCLES = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] almost_empty;
    logic              m_axis_tready;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic [NUM_CH-1:0] rd_en;
    logic [2:0]        sel;
    logic              pkt_hdr;
    logic [15:0]       hdr_data;

    int cnt [NUM_CH];
    int pass_n  = 0;
    int total_n = 0;

    adc_rr_pkt_scheduler #(
        .NUM_CH(NUM_CH), .PKT_LEN(PKT_LEN), .GAP_CYCLES(GAP_CYCLES), .CNT_W(16)
    ) dut (
        .clk(clk), .rstn(rstn), .full(full), .empty(empty), .almost_empty(almost_empty),
        .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .rd_en(rd_en), .sel(sel), .pkt_hdr(pkt_hdr), .hdr_data(hdr_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        empty        = '0;
        almost_empty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i]        = (cnt[i] == 0);
            almost_empty[i] = (cnt[i] == 1);
        end
    end

    // One clock: pops seen before the edge are applied just after it; returns at the falling edge.
    task automatic step();
        logic [NUM_CH-1:0] snap;
        snap = rd_en;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) if (snap[i] && cnt[i] > 0) cnt[i]--;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        full = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic collect(input bit toggle, output int beats, output int sel0, output int lead,
                           output int hdr_n, output logic [15:0] hdr_v, output bit bad_sel,
                           output bit rd_bad, output bit tmo);
        bit started = 0;
        bit done = 0;
        beats = 0; sel0 = -1; lead = 0; hdr_n = 0; hdr_v = '0; bad_sel = 0; rd_bad = 0; tmo = 1;
        for (int c = 0; c < 300; c++) begin
            m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
            #1;
            if (!started && !m_axis_tvalid) lead++;
            if (m_axis_tvalid) started = 1;
            if (!(m_axis_tvalid && m_axis_tready) && rd_en != '0) rd_bad = 1;
            if (m_axis_tlast && !m_axis_tvalid) rd_bad = 1;
            if (m_axis_tvalid && m_axis_tready) begin
                if (pkt_hdr) begin
                    hdr_n++;
                    hdr_v = hdr_data;
                    if (rd_en != '0) rd_bad = 1;
                end else begin
                    beats++;
                    if (sel0 < 0) sel0 = int'(sel);
                    else if (int'(sel) != sel0) bad_sel = 1;
                    if (rd_en != NUM_CH'(1 << sel)) rd_bad = 1;
                    if (m_axis_tlast) done = 1;
                end
            end
            step();
            if (done) begin
                tmo = 0;
                break;
            end
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total_n++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %0b exp 0", m_axis_tvalid); else pass_n++;
        total_n++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got %0b exp 0", m_axis_tlast); else pass_n++;
        total_n++; if (rd_en !== 6'h00) $display("FAIL reset_rd_en got %h exp 00", rd_en); else pass_n++;
        total_n++; if (sel !== 3'd0) $display("FAIL reset_sel got %0d exp 0", sel); else pass_n++;
        total_n++; if (pkt_hdr !== 1'b0) $display("FAIL reset_pkt_hdr got %0b exp 0", pkt_hdr); else pass_n++;
        total_n++; if (hdr_data !== 16'h0000) $display("FAIL reset_hdr_data got %h exp 0000", hdr_data); else pass_n++;
    endtask

    task automatic test_single_channel();
        int b, s, l, hn; logic [15:0] hv; bit bs, rb, tm;
        int exp_beats [3] = '{8, 8, 4};
        int exp_lead  [3] = '{0, GAP_CYCLES + 1, GAP_CYCLES + 1};
        apply_reset();
        cnt[2] = 20;
        full = 1'b1;
        #1;
        total_n++; if (m_axis_tvalid !== 1'b0) $display("FAIL lat_idle got %0b exp 0", m_axis_tvalid); else pass_n++;
        step(); #1;
        total_n++; if (m_axis_tvalid !== 1'b0) $display("FAIL lat_arb got %0b exp 0", m_axis_tvalid); else pass_n++;
        step(); #1;
        total_n++; if (m_axis_tvalid !== 1'b1) $display("FAIL lat_send got %0b exp 1", m_axis_tvalid); else pass_n++;
        total_n++; if (sel !== 3'd2) $display("FAIL lat_sel got %0d exp 2", sel); else pass_n++;
        for (int p = 0; p < 3; p++) begin
            collect(1'b0, b, s, l, hn, hv, bs, rb, tm);
            total_n++; if (tm !== 1'b0) $display("FAIL single_timeout pkt %0d got %0b exp 0", p, tm); else pass_n++;
            total_n++; if (b !== exp_beats[p]) $display("FAIL single_beats pkt %0d got %0d exp %0d", p, b, exp_beats[p]); else pass_n++;
            total_n++; if (s !== 2 || bs !== 1'b0) $display("FAIL single_sel pkt %0d got %0d exp 2", p, s); else pass_n++;
            total_n++; if (l !== exp_lead[p]) $display("FAIL single_gap pkt %0d got %0d exp %0d", p, l, exp_lead[p]); else pass_n++;
            total_n++; if (rb !== 1'b0) $display("FAIL single_rd_en pkt %0d got %0b exp 0", p, rb); else pass_n++;
`ifndef ADC_SCHED_HDR_EN
            total_n++; if (hn !== 0) $display("FAIL single_no_hdr pkt %0d got %0d exp 0", p, hn); else pass_n++;
`endif
        end
        begin
            bit seen = 0;
            for (int c = 0; c < 3 * GAP_CYCLES; c++) begin
                #1;
                if (m_axis_tvalid || rd_en != '0) seen = 1;
                step();
            end
            total_n++; if (seen !== 1'b0) $display("FAIL drained_idle got %0b exp 0", seen); else pass_n++;
        end
        full = 1'b0;
    endtask

    task automatic test_round_robin();
        int b, s, l, hn; logic [15:0] hv; bit bs, rb, tm;
        apply_reset();
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 16;
        full = 1'b1;
        for (int k = 0; k < NUM_CH + 1; k++) begin
            collect(1'b0, b, s, l, hn, hv, bs, rb, tm);
            total_n++; if (tm !== 1'b0 || b !== PKT_LEN) $display("FAIL rr_beats pkt %0d got %0d exp %0d", k, b, PKT_LEN); else pass_n++;
            total_n++; if (s !== (k % NUM_CH) || bs !== 1'b0) $display("FAIL rr_grant pkt %0d got %0d exp %0d", k, s, k % NUM_CH); else pass_n++;
        end
        full = 1'b0;
    endtask

    task automatic test_backpressure();
        int b, s, l, hn; logic [15:0] hv; bit bs, rb, tm;
        apply_reset();
        cnt[1] = 5;
        full = 1'b1;
        collect(1'b1, b, s, l, hn, hv, bs, rb, tm);
        total_n++; if (tm !== 1'b0 || b !== 5) $display("FAIL bp_beats got %0d exp 5", b); else pass_n++;
        total_n++; if (s !== 1) $display("FAIL bp_sel got %0d exp 1", s); else pass_n++;
        total_n++; if (rb !== 1'b0) $display("FAIL bp_rd_en got %0b exp 0", rb); else pass_n++;
        total_n++; if (cnt[1] !== 0) $display("FAIL bp_fifo_left got %0d exp 0", cnt[1]); else pass_n++;
        full = 1'b0;
    endtask

    task automatic test_underrun();
        int b, s, l, hn; logic [15:0] hv; bit bs, rb, tm;
        int d = 0;
        bit tv_bad = 0, sel_bad = 0, pop_bad = 0;
        apply_reset();
        cnt[0] = 100;
        full = 1'b1;
        for (int c = 0; c < 50 && d < 3; c++) begin
            #1;
            if (m_axis_tvalid && m_axis_tready && !pkt_hdr) d++;
            step();
        end
        cnt[0] = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (m_axis_tvalid) tv_bad = 1;
            if (sel !== 3'd0) sel_bad = 1;
            if (rd_en != '0) pop_bad = 1;
            step();
        end
        total_n++; if (tv_bad !== 1'b0) $display("FAIL underrun_tvalid got %0b exp 0", tv_bad); else pass_n++;
        total_n++; if (sel_bad !== 1'b0 || pop_bad !== 1'b0) $display("FAIL underrun_hold got %0b/%0b exp 0/0", sel_bad, pop_bad); else pass_n++;
        cnt[0] = 100;
        collect(1'b0, b, s, l, hn, hv, bs, rb, tm);
        total_n++; if (tm !== 1'b0 || b !== PKT_LEN - 3) $display("FAIL underrun_resume got %0d exp %0d", b, PKT_LEN - 3); else pass_n++;
        total_n++; if (s !== 0 || l !== 0) $display("FAIL underrun_sel_lead got %0d/%0d exp 0/0", s, l); else pass_n++;
        full = 1'b0;
    endtask

    task automatic test_reset_mid();
        int b, s, l, hn; logic [15:0] hv; bit bs, rb, tm;
        int d = 0;
        apply_reset();
        cnt[0] = 100;
        cnt[1] = 100;
        full = 1'b1;
        for (int c = 0; c < 50 && d < 4; c++) begin
            #1;
            if (m_axis_tvalid && m_axis_tready && !pkt_hdr) d++;
            step();
        end
        #1;
        total_n++; if (m_axis_tvalid !== 1'b1) $display("FAIL midrst_pre_tvalid got %0b exp 1", m_axis_tvalid); else pass_n++;
        rstn = 1'b0;
        #1;
        total_n++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) $display("FAIL midrst_valid_last got %0b/%0b exp 0/0", m_axis_tvalid, m_axis_tlast); else pass_n++;
        total_n++; if (rd_en !== 6'h00 || sel !== 3'd0) $display("FAIL midrst_rd_sel got %h/%0d exp 00/0", rd_en, sel); else pass_n++;
        step();
        rstn = 1'b1;
        collect(1'b0, b, s, l, hn, hv, bs, rb, tm);
        total_n++; if (tm !== 1'b0 || s !== 0) $display("FAIL midrst_first_grant got %0d exp 0", s); else pass_n++;
        total_n++; if (b !== PKT_LEN) $display("FAIL midrst_beats got %0d exp %0d", b, PKT_LEN); else pass_n++;
        full = 1'b0;
    endtask

`ifdef ADC_SCHED_HDR_EN
    task automatic test_header();
        int b, s, l, hn; logic [15:0] hv; bit bs, rb, tm;
        logic [15:0] exp_hdr [2] = '{16'h0003, 16'h000B};
        apply_reset();
        cnt[3] = 20;
        full = 1'b1;
        for (int p = 0; p < 2; p++) begin
            collect(1'b0, b, s, l, hn, hv, bs, rb, tm);
            total_n++; if (tm !== 1'b0 || hn !== 1) $display("FAIL hdr_count pkt %0d got %0d exp 1", p, hn); else pass_n++;
            total_n++; if (hv !== exp_hdr[p]) $display("FAIL hdr_data pkt %0d got %h exp %h", p, hv, exp_hdr[p]); else pass_n++;
            total_n++; if (b !== PKT_LEN || rb !== 1'b0) $display("FAIL hdr_beats pkt %0d got %0d exp %0d", p, b, PKT_LEN); else pass_n++;
        end
        full = 1'b0;
    endtask
`endif

    initial begin
        rstn = 1'b1;
        full = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        #2 rstn = 1'b0;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_underrun();
        test_reset_mid();
`ifdef ADC_SCHED_HDR_EN
        test_header();
`endif
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
